simon_sequencer: RTL and testbench

- Game-flow controller for the Simon clone. It owns the LFSR control pins (step, rerun, randomize).
- While idle it seeds the LFSR by free-running it. On each level it replays the stored colour sequence from the captured seed, then replays it again internally to check the player's button presses.
- It tracks the level, an input timeout, and the win and lose outcomes. It sits between the button/LED I/O and the LFSR.

---
 rtl/simon_pkg.sv | 22 ++
 rtl/simon_tick_timer.sv | 27 ++
 rtl/simon_sequencer.sv | 168 ++++++++++++++++
 tb/tb_simon_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared state encoding and colour constants for the Simon sequencer
package simon_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        PLOAD,
        SHOW_ON,
        SHOW_OFF,
        ILOAD,
        IWAIT,
        LVLUP,
        LOSE,
        WIN
    } state_t;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] GREEN  = 2'd1;
    localparam logic [1:0] BLUE   = 2'd2;
    localparam logic [1:0] YELLOW = 2'd3;

endpackage

// File: rtl/simon_tick_timer.sv
// rtl/simon_tick_timer.sv - clearable tick counter with a programmable terminal count
module simon_tick_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] cnt;

    // done fires combinationally on the tick that completes the count, so a tick
    // arriving in the first cycle after a clear already counts as tick number one
    assign done = tick && (cnt == terminal - W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon game-flow controller driving LFSR control, playback LEDs and outcome
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEVEL     = 16,
    parameter int LEVEL_W       = 5,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 20,
    parameter int TICK_W        = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               btn_valid,
    input  logic [1:0]         btn_color,
    input  logic [3:0]         lfsr_look,
    output logic               lfsr_step,
    output logic               lfsr_rerun,
    output logic               lfsr_randomize,
    output logic               led_on,
    output logic [1:0]         led_color,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               game_over,
    output logic               win
);

    state_t             state, state_next;
    logic [LEVEL_W-1:0] idx, idx_next, level_next;
    logic               led_on_next;
    logic [1:0]         led_color_next;
    logic               timer_clr, timer_done, more;
    logic [TICK_W-1:0]  terminal;
    logic               unused_look;

    assign unused_look = ^lfsr_look[3:2];
    assign more        = (idx + LEVEL_W'(1)) < level;

    always_comb begin
        case (state)
            SHOW_ON:  terminal = TICK_W'(ON_TICKS);
            SHOW_OFF: terminal = TICK_W'(OFF_TICKS);
            default:  terminal = TICK_W'(TIMEOUT_TICKS);
        endcase
    end

    simon_tick_timer #(.W(TICK_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clr),
        .tick     (tick),
        .terminal (terminal),
        .done     (timer_done)
    );

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        level_next     = level;
        led_on_next    = led_on;
        led_color_next = led_color;
        timer_clr      = 1'b0;
        lfsr_step      = 1'b0;
        lfsr_rerun     = 1'b0;
        lfsr_randomize = 1'b0;
        case (state)
            IDLE: begin
                lfsr_randomize = 1'b1;
                level_next     = '0;
                if (start) begin
                    level_next = LEVEL_W'(1);
                    state_next = ARM;
                end
            end
            ARM: state_next = PLOAD;
            PLOAD, ILOAD: begin
                lfsr_rerun = 1'b1;
                idx_next   = '0;
                state_next = (state == PLOAD) ? SHOW_ON : IWAIT;
            end
            SHOW_ON: begin
                // the LFSR output settles in the entry cycle, so the colour is latched here
                if (!led_on) begin
                    led_on_next    = 1'b1;
                    led_color_next = lfsr_look[1:0];
                end
                if (timer_done) begin
                    led_on_next = 1'b0;
                    state_next  = SHOW_OFF;
                end
            end
            SHOW_OFF: begin
                if (timer_done) begin
                    if (more) begin
                        lfsr_step  = 1'b1;
                        idx_next   = idx + LEVEL_W'(1);
                        state_next = SHOW_ON;
                    end else begin
                        state_next = ILOAD;
                    end
                end
            end
            IWAIT: begin
                if (btn_valid) begin
                    if (btn_color != lfsr_look[1:0]) begin
                        state_next = LOSE;
                    end else if (more) begin
                        lfsr_step = 1'b1;
                        idx_next  = idx + LEVEL_W'(1);
                        timer_clr = 1'b1;
                    end else begin
                        state_next = LVLUP;
                    end
                end else if (timer_done) begin
                    state_next = LOSE;
                end
            end
            LVLUP: begin
                if (level == LEVEL_W'(MAX_LEVEL)) begin
                    state_next = WIN;
                end else begin
                    level_next = level + LEVEL_W'(1);
                    state_next = PLOAD;
                end
            end
            LOSE, WIN: begin
                if (start) begin
                    level_next = LEVEL_W'(1);
                    state_next = ARM;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) begin
            timer_clr = 1'b1;
        end
        if (reset) begin
            lfsr_step      = 1'b0;
            lfsr_rerun     = 1'b0;
            lfsr_randomize = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            level     <= '0;
            led_on    <= 1'b0;
            led_color <= 2'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            level     <= level_next;
            led_on    <= led_on_next;
            led_color <= led_color_next;
            busy      <= !(state_next inside {IDLE, LOSE, WIN});
            game_over <= (state_next == LOSE);
            win       <= (state_next == WIN);
        end
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - directed self-checking bench for simon_sequencer with a scripted colour source
module tb_simon_sequencer;
    import simon_pkg::*;

    localparam int ON_T  = 4;
    localparam int OFF_T = 2;

    logic       clk = 1'b0;
    logic       reset, tick, start, btn_valid;
    logic [1:0] btn_color;
    logic [3:0] lfsr_look;
    logic       lfsr_step, lfsr_rerun, lfsr_randomize, led_on, busy, game_over, win;
    logic [1:0] led_color;
    logic [4:0] level;

    int errors = 0;
    int checks = 0;
    int step_cnt = 0;

    // scripted colour source standing in for the LFSR: rerun rewinds, step advances
    logic [1:0] seq [0:3];
    logic [1:0] pos = 2'd0;
    assign lfsr_look = {2'b00, seq[pos]};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lfsr_rerun) pos <= 2'd0;
        else if (lfsr_step) pos <= pos + 2'd1;
        if (lfsr_step) step_cnt <= step_cnt + 1;
    end

    simon_sequencer #(
        .MAX_LEVEL(2), .LEVEL_W(5), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T),
        .TIMEOUT_TICKS(20), .TICK_W(5)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .btn_valid(btn_valid), .btn_color(btn_color), .lfsr_look(lfsr_look),
        .lfsr_step(lfsr_step), .lfsr_rerun(lfsr_rerun), .lfsr_randomize(lfsr_randomize),
        .led_on(led_on), .led_color(led_color), .level(level), .busy(busy),
        .game_over(game_over), .win(win)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(lfsr_step && lfsr_rerun)) else begin
                errors++;
                $error("FAIL step_rerun_excl: observed step=%0b rerun=%0b expected not both", lfsr_step, lfsr_rerun);
            end
            if (lfsr_randomize) begin
                checks++;
                assert (!busy && level == 5'd0 && !game_over && !win) else begin
                    errors++;
                    $error("FAIL randomize_idle_only: observed busy=%0b level=%0d expected idle", busy, level);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tick(input bit noise, input logic [1:0] wrong);
        tick = 1'b1;
        if (noise) begin
            btn_valid = 1'b1;
            btn_color = wrong;
            start     = 1'b1;
        end
        cycle();
        tick = 1'b0;
        btn_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] col);
        btn_valid = 1'b1;
        btn_color = col;
        cycle();
        btn_valid = 1'b0;
    endtask

    // plays back n colours, checking colour, on/off tick counts, step count and the ILOAD rerun
    task automatic play_level(input int n, input bit noise);
        int s0;
        s0 = step_cnt;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8 && led_on !== 1'b1; k++) cycle();
            chk("led_rise", led_on, 1'b1);
            chk("led_color", led_color, seq[i]);
            chk("busy_play", busy, 1'b1);
            for (int t = 0; t < ON_T - 1; t++) drive_tick(noise, ~seq[i]);
            chk("led_hold", led_on, 1'b1);
            drive_tick(noise, ~seq[i]);
            chk("led_off", led_on, 1'b0);
            for (int t = 0; t < OFF_T - 1; t++) drive_tick(noise, ~seq[i]);
            chk("gap_no_rerun", lfsr_rerun, 1'b0);
            drive_tick(noise, ~seq[i]);
        end
        chk("iload_rerun", lfsr_rerun, 1'b1);
        cycle();
        chk("rerun_one_cycle", lfsr_rerun, 1'b0);
        chk("step_pulses", step_cnt - s0, n - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        seq[0] = RED; seq[1] = BLUE; seq[2] = GREEN; seq[3] = YELLOW;
        reset = 1'b1; tick = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_color = 2'd0;
        repeat (3) cycle();
        chk("rst_randomize", lfsr_randomize, 1'b0);
        chk("rst_level", level, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_led", led_on, 1'b0);

        reset = 1'b0;
        cycle();
        chk("idle_randomize", lfsr_randomize, 1'b1);
        chk("idle_level", level, 5'd0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_flags", {game_over, win}, 2'b00);

        // start and a press together in IDLE: start wins
        start = 1'b1; btn_valid = 1'b1; btn_color = YELLOW;
        cycle();
        start = 1'b0; btn_valid = 1'b0;
        chk("arm_level", level, 5'd1);
        chk("arm_busy", busy, 1'b1);
        chk("arm_randomize", lfsr_randomize, 1'b0);
        cycle();
        chk("pload_rerun", lfsr_rerun, 1'b1);
        chk("pload_step", lfsr_step, 1'b0);

        play_level(1, 1'b0);
        press(RED);
        chk("lvlup_level", level, 5'd1);
        chk("lvlup_go", game_over, 1'b0);
        cycle();
        chk("level2", level, 5'd2);
        play_level(2, 1'b0);

        press(RED);
        press(GREEN);
        chk("lose_go", game_over, 1'b1);
        chk("lose_level", level, 5'd2);
        chk("lose_busy", busy, 1'b0);

        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("restart_level", level, 5'd1);
        chk("restart_go", game_over, 1'b0);
        play_level(1, 1'b0);

        // press on the 20th tick beats the timeout
        repeat (19) drive_tick(1'b0, 2'd0);
        chk("no_early_timeout", game_over, 1'b0);
        tick = 1'b1; btn_valid = 1'b1; btn_color = RED;
        cycle();
        tick = 1'b0; btn_valid = 1'b0;
        chk("press_wins", game_over, 1'b0);
        cycle();
        chk("press_wins_level", level, 5'd2);
        play_level(2, 1'b1);

        repeat (19) drive_tick(1'b0, 2'd0);
        chk("timeout_19", game_over, 1'b0);
        drive_tick(1'b0, 2'd0);
        chk("timeout_20", game_over, 1'b1);
        chk("timeout_busy", busy, 1'b0);

        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("replay_level", level, 5'd1);
        play_level(1, 1'b0);
        press(RED);
        cycle();
        play_level(2, 1'b1);
        press(RED);
        press(BLUE);
        cycle();
        chk("win_flag", win, 1'b1);
        chk("win_level", level, 5'd2);
        chk("win_busy", busy, 1'b0);
        chk("win_go", game_over, 1'b0);

        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("win_restart_flag", win, 1'b0);
        cycle();
        reset = 1'b1;
        cycle();
        chk("midrst_level", level, 5'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rerun", lfsr_rerun, 1'b0);
        reset = 1'b0;
        cycle();
        chk("midrst_idle", lfsr_randomize, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
